pa_f_spsram_ctrl: RTL
=====================

// Module: pa_f_spsram_ctrl
// PURPOSE
//  Initiator-side controller for the pa_f_spsram_2048x32 single-port SRAM. Drives A/CEN/GWEN/WEN/D
//  and captures Q. After reset it zero-fills the array, then serves valid/ready read/write
//  requests from a client. Read data returns through an in-order response FIFO with backpressure.
//  It sits between a client (tightly-coupled memory or buffer logic) and the SRAM instance.
// PARAMETERS
//  ADDR_WIDTH  11           SRAM address width; array depth = 2**ADDR_WIDTH words
//  DATA_WIDTH  32           word width; must be a multiple of 8
//  INIT_EN     1            1: fill the whole array with INIT_DATA after reset; 0: skip the fill
//  INIT_DATA   32'h0        fill pattern
//  RSP_DEPTH   4            response FIFO entries; >=3 is required for 1 read/cycle at rsp_rdy=1
// PORTS
//  cpuclk      in   1             clock; the SRAM CLK is tied to this clock
//  cpurst_b    in   1             asynchronous reset, active low
//  req_vld     in   1             request valid
//  req_rdy     out  1             request ready; a request is accepted when req_vld & req_rdy
//  req_wr      in   1             1 = write, 0 = read
//  req_addr    in   ADDR_WIDTH    word address
//  req_wdata   in   DATA_WIDTH    write data
//  req_bmask   in   DATA_WIDTH/8  byte write enables, active high
//  rsp_vld     out  1             read response valid (FIFO not empty)
//  rsp_rdy     in   1             response pop when rsp_vld & rsp_rdy
//  rsp_rdata   out  DATA_WIDTH    read data at the FIFO head
//  init_done   out  1             array fill complete; requests can be accepted
//  sram_a      out  ADDR_WIDTH    to SRAM A
//  sram_cen    out  1             to SRAM CEN (active low)
//  sram_gwen   out  1             to SRAM GWEN (active low)
//  sram_wen    out  DATA_WIDTH    to SRAM WEN (per-bit, active low)
//  sram_d      out  DATA_WIDTH    to SRAM D
//  sram_q      in   DATA_WIDTH    from SRAM Q; valid in the cycle after the read edge
// BEHAVIOUR
//  - Reset values: req_rdy=0, rsp_vld=0, rsp_rdata=0, init_done=0, FIFO empty, in-flight flag=0,
//    init counter=0.
//    SRAM outputs in the idle pattern: sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
//  - Idle pattern: whenever no access is issued in a cycle, the SRAM outputs hold the idle pattern.
//  - FSM states are INIT and RUN. The FSM enters INIT on reset.
//  - INIT, INIT_EN=1:
//    - One write per cycle: cen=0, gwen=0, wen=0, a=cnt, d=INIT_DATA. cnt counts 0..2**ADDR_WIDTH-1.
//    - The first cycle after reset release writes address 0. The last write is in cycle 2**ADDR_WIDTH.
//    - After the last write the FSM goes to RUN and init_done=1 from the next cycle.
//  - INIT, INIT_EN=0: the FSM goes to RUN at the first edge after reset release, with no SRAM access.
//  - RUN: init_done=1 and stays 1 until the next reset. Request outputs are combinational from the
//    request in the accepting cycle.
//  - Write accept: cen=0, gwen=0, a=req_addr, d=req_wdata, wen[i]=~req_bmask[i/8].
//    - With req_bmask==0 the request is accepted and the idle pattern is driven (no access).
//    - Writes produce no response.
//  - Read accept: cen=0, gwen=1, wen=all 1, a=req_addr. The in-flight flag is set for one cycle.
//    - sram_q is pushed into the FIFO at the end of that next cycle.
//    - rsp_vld rises 2 cycles after the accept edge.
//  - req_rdy in RUN: writes are always accepted. Reads are accepted only while
//    fifo_cnt + inflight < RSP_DEPTH. req_rdy has no combinational path from rsp_rdy.
//  - FIFO: push and pop in the same cycle are allowed; the count is then unchanged.
//    Pointers wrap modulo RSP_DEPTH. Responses return in request order.
//  - Ordering: a read issued the cycle after a write to the same address returns the new data.
//  - Reset mid-operation: all state clears at once (asynchronous). In-flight and buffered reads
//    are dropped, rsp_vld falls immediately, and INIT restarts at address 0.
// TESTING
//  T1 reset release, INIT_EN=1 -> 2048 consecutive writes, addr 0..2047, D=0, WEN=0;
//     init_done=1 at cycle 2049; req_rdy=0 throughout the fill.
//  T2 write 0x123 data 0xDEADBEEF bmask 4'hF, then read 0x123
//     -> rsp_vld 2 cycles after the read accept, rsp_rdata=0xDEADBEEF.
//  T3 on top of T2, write 0x123 data 0x0000AA00 bmask 4'b0010, then read 0x123
//     -> rsp_rdata=0xDEADAAEF. A zero-bmask write -> no CEN-low cycle.
//  T4 8 back-to-back reads of addresses 0..7 (preloaded with value=addr), rsp_rdy=1
//     -> req_rdy stays 1; 8 consecutive responses 0..7 in order.
//  T5 rsp_rdy=0 with continuous reads -> exactly 4 accepted, then req_rdy=0 for reads
//     (writes still accepted); rsp_rdy=1 -> 4 responses drain in order.
//  T6 cpurst_b asserted with fifo_cnt=2 and a read in flight -> rsp_vld=0 and idle pattern
//     immediately; after release INIT restarts at address 0.

Source files
------------

// File: rtl/pa_f_spsram_ctrl_if.sv
// Client-side request/response bundle for the single-port SRAM controller.
// The controller is the slave; the client (TCM or buffer logic) is the master.
interface pa_f_spsram_ctrl_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
);
    logic                      req_vld;
    logic                      req_rdy;
    logic                      req_wr;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic [DATA_WIDTH/8-1:0]   req_bmask;
    logic                      rsp_vld;
    logic                      rsp_rdy;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      init_done;

    modport master (
        output req_vld, req_wr, req_addr, req_wdata, req_bmask, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_rdata, init_done
    );

    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, req_bmask, rsp_rdy,
        output req_rdy, rsp_vld, rsp_rdata, init_done
    );
endinterface

// File: rtl/pa_f_spsram_ctrl.sv
// Initiator-side controller for a single-port SRAM: post-reset array fill, then
// valid/ready read/write service with an in-order, backpressured read-response FIFO.
module pa_f_spsram_ctrl #(
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    DATA_WIDTH = 32,
    parameter bit                    INIT_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_DATA  = '0,
    parameter int                    RSP_DEPTH  = 4
) (
    input  logic                  cpuclk,
    input  logic                  cpurst_b,
    pa_f_spsram_ctrl_if.slave     bus,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  init_done_q;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_cnt;
    logic [CW:0]           occupancy;
    logic                  fill_wr;
    logic                  space;
    logic                  accept;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state       <= ST_INIT;
            init_cnt    <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (!INIT_EN || init_cnt == '1) begin
                        state       <= ST_RUN;
                        init_done_q <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Fill writes are gated by reset so the SRAM sees the idle pattern while reset is held.
    assign fill_wr   = (state == ST_INIT) && INIT_EN && cpurst_b;
    assign occupancy = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight};
    assign space     = occupancy < (CW + 1)'(RSP_DEPTH);

    assign bus.init_done = init_done_q;
    assign bus.req_rdy   = init_done_q && (bus.req_wr || space);
    assign accept        = bus.req_vld && bus.req_rdy;
    assign rd_acc        = accept && !bus.req_wr;
    assign wr_acc        = accept && bus.req_wr && (|bus.req_bmask);

    always_comb begin
        // NOTE: every output gets its idle value first, so no path through this block can infer a latch.
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (fill_wr) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = init_cnt;
            sram_d    = INIT_DATA;
        end else if (wr_acc) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_a    = bus.req_addr;
            sram_d    = bus.req_wdata;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                sram_wen[i] = ~bus.req_bmask[i/8];
            end
        end else if (rd_acc) begin
            sram_cen = 1'b0;
            sram_a   = bus.req_addr;
        end
    end

    assign bus.rsp_vld   = (fifo_cnt != '0);
    assign bus.rsp_rdata = bus.rsp_vld ? fifo_mem[rd_ptr] : '0;
    assign pop           = bus.rsp_vld && bus.rsp_rdy;

    // Admission control guarantees a free slot for every in-flight read, so a push never overflows.
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            inflight <= rd_acc;
            if (inflight) wr_ptr <= next_ptr(wr_ptr);
            if (pop)      rd_ptr <= next_ptr(rd_ptr);
            case ({inflight, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // NOTE: the storage array has no reset; rsp_rdata is forced to zero while the FIFO is empty.
    always_ff @(posedge cpuclk) begin
        if (inflight) fifo_mem[wr_ptr] <= sram_q;
    end
endmodule
